// File: rtl/dmem_ws.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_ws : wait-state byte/half/word data memory with stall handshake      |
// |           optional macro DMEM_MISALIGN_ERR_EN flags misaligned accesses    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dmem_ws #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic        Err
);
    localparam int         IDXW     = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            active;
    logic [31:0]     mem [DEPTH];
    logic [IDXW-1:0] idx;
    logic [31:0]     word;
    logic            misalign;
    logic            done;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [31:0]     load_val;
    logic [3:0]      lane_en;
    logic [31:0]     lane_data;
    logic            unused_addr;

    assign idx         = DataAdr[IDXW+1:2];
    assign word        = mem[idx];
    assign unused_addr = ^DataAdr[31:IDXW+2];

`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign = ((Size == 2'b01) && DataAdr[0]) ||
                      (Size[1] && (DataAdr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // active keeps a zero-wait request from completing while reset is held
    assign done = active && ((state == S_DONE) ||
                  ((WAIT_STATES == 0) && (state == S_IDLE) && Req));

    assign Done     = done;
    assign Stall    = Req & ~done;
    assign Err      = done & misalign;
    assign ReadData = (done && !misalign) ? load_val : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            active <= 1'b0;
        end else begin
            active <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (Req && (WAIT_STATES != 0)) begin
                        state <= (CNT_LOAD == 4'd0) ? S_DONE : S_WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (!Req) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd1) begin
                        state <= S_DONE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        sel_byte = word[{DataAdr[1:0], 3'b000} +: 8];
        sel_half = DataAdr[1] ? word[31:16] : word[15:0];
        case (Size)
            2'b00:   load_val = {{24{sel_byte[7] & ~Unsigned}}, sel_byte};
            2'b01:   load_val = {{16{sel_half[15] & ~Unsigned}}, sel_half};
            default: load_val = word;
        endcase
    end

    // Store data is replicated across lanes so the enable alone picks the target
    always_comb begin
        case (Size)
            2'b00: begin
                lane_en   = 4'b0001 << DataAdr[1:0];
                lane_data = {4{WriteData[7:0]}};
            end
            2'b01: begin
                lane_en   = DataAdr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{WriteData[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = WriteData;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (done && MemWrite && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ws.sv
`default_nettype none
// tb_dmem_ws : three instances (0, 2, 3 wait states) driven by a vector table,
// directed reset/abort sequences and random accesses against a byte-array model.
module tb_dmem_ws;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [3];
    logic        we    [3];
    logic [1:0]  sz    [3];
    logic        uns   [3];
    logic [31:0] adr   [3];
    logic [31:0] wd    [3];
    logic [31:0] rd    [3];
    logic        stall [3];
    logic        done  [3];
    logic        err   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        dmem_ws #(.DEPTH(64), .WAIT_STATES(WS)) u_dut (
            .clk(clk), .reset(rst_n), .Req(req[g]), .MemWrite(we[g]),
            .Size(sz[g]), .Unsigned(uns[g]), .DataAdr(adr[g]),
            .WriteData(wd[g]), .ReadData(rd[g]), .Stall(stall[g]),
            .Done(done[g]), .Err(err[g])
        );
    end

`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic        u;
        logic [31:0] a;
        logic [31:0] wdat;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t       tbl [22];
    logic [7:0] mb [3][256];
    int         n_chk  = 0;
    int         n_fail = 0;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: memory as 256 bytes; access covers the naturally aligned unit
    task automatic model(input int d, input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a_in, input logic [31:0] wdat,
                         output logic [31:0] erd, output logic eerr);
        int a, n, base;
        logic [31:0] v;
        a    = int'(a_in[7:0]);
        n    = (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
        base = a - (a % n);
        erd  = 32'd0;
        eerr = MIS && ((a % n) != 0);
        if (eerr) return;
        if (w) begin
            for (int i = 0; i < n; i++) mb[d][base + i] = wdat[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(mb[d][base + i]) << (8 * i));
            if (!u && n < 4 && v[8*n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            erd = v;
        end
    endtask

    // Presents one request (called just after a rising edge) and waits for Done
    task automatic access(input int d, input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] wdat,
                          output logic [31:0] drd, output logic derr);
        int k;
        bit got, stall_ok;
        k = 0; got = 0; stall_ok = 1; drd = 32'd0; derr = 1'b0;
        req[d] = 1'b1; we[d] = w; sz[d] = s; uns[d] = u; adr[d] = a; wd[d] = wdat;
        while (!got && k <= 20) begin
            @(negedge clk);
            if (done[d] === 1'b1) begin
                got  = 1;
                drd  = rd[d];
                derr = err[d];
                if (stall[d] !== 1'b0) stall_ok = 0;
            end else begin
                if (stall[d] !== 1'b1) stall_ok = 0;
                k++;
            end
        end
        check($sformatf("latency d%0d a=%h", d, a), got ? 64'(k) : 64'hFFFF, 64'(ws_of(d)));
        check($sformatf("stall d%0d a=%h", d, a), 64'(stall_ok), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic txn(input int d, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] wdat,
                       output logic [31:0] drd, output logic derr,
                       output logic [31:0] mrd, output logic merr);
        model(d, w, s, u, a, wdat, mrd, merr);
        access(d, w, s, u, a, wdat, drd, derr);
    endtask

    task automatic idle(input int d, input int n);
        req[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("idle_quiet d%0d", d),
                  {29'd0, done[d], err[d], stall[d], rd[d]}, 64'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] drd, mrd, wdat, a;
        logic        derr, merr, w, u;
        logic [1:0]  s;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h13,  32'h00000080, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'h00000080, 1'b0};
        tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0};
        tbl[6]  = '{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'hFFFF80AD, 1'b0};
        tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h10,  32'h0,        32'h0000BEEF, 1'b0};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h16,  32'hFFFF1234, 32'h0,        1'b0};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h14,  32'h0,        32'h12340505, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 32'h15,  32'h0,        32'h00000005, 1'b0};
        tbl[12] = '{1'b0, 2'd1, 1'b0, 32'h14,  32'h0,        32'h00000505, 1'b0};
        tbl[13] = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h300, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[16] = '{1'b1, 2'd2, 1'b0, 32'h22,  32'h77665544, 32'h0,        MIS};
        tbl[17] = '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0, MIS ? 32'h08080808 : 32'h77665544, 1'b0};
        tbl[18] = '{1'b0, 2'd1, 1'b0, 32'h11,  32'h0, MIS ? 32'h0 : 32'hFFFFBEEF, MIS};
        tbl[19] = '{1'b0, 2'd0, 1'b0, 32'h21,  32'h0, MIS ? 32'h08 : 32'h55, 1'b0};
        tbl[20] = '{1'b1, 2'd0, 1'b0, 32'h3F,  32'h000000AB, 32'h0,        1'b0};
        tbl[21] = '{1'b0, 2'd1, 1'b0, 32'h3E,  32'h0,        32'hFFFFAB0F, 1'b0};

        // Reset values, with Req held high so Stall must follow it
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b1; we[d] = 1'b0; sz[d] = 2'd2; uns[d] = 1'b0;
            adr[d] = 32'd0; wd[d] = 32'd0;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            check($sformatf("reset d%0d {done,err,stall,rd}", d),
                  {29'd0, done[d], err[d], stall[d], rd[d]}, {29'd0, 3'b001, 32'd0});
        for (int d = 0; d < 3; d++) req[d] = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check($sformatf("reset d%0d stall", d), 64'(stall[d]), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Known contents: word i = i * 0x01010101
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 64; i++)
                txn(d, 1'b1, 2'd2, 1'b0, 32'(4 * i), 32'h01010101 * 32'(i), drd, derr, mrd, merr);
            idle(d, 1);
        end

        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < 22; r++) begin
                txn(d, tbl[r].w, tbl[r].s, tbl[r].u, tbl[r].a, tbl[r].wdat, drd, derr, mrd, merr);
                check($sformatf("tbl%0d d%0d err", r, d), 64'(derr), 64'(tbl[r].eerr));
                if (!tbl[r].w) check($sformatf("tbl%0d d%0d rdata", r, d), 64'(drd), 64'(tbl[r].erd));
            end
            idle(d, 1);
        end

        // Reset asserted while a store sits in WAIT
        txn(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11111111, drd, derr, mrd, merr);
        req[1] = 1'b1; we[1] = 1'b1; sz[1] = 2'd2; adr[1] = 32'h20; wd[1] = 32'h22222222;
        @(negedge clk);
        check("rst_seq pre stall", 64'({stall[1], done[1]}), 64'b10);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("rst_seq done at assert", 64'(done[1]), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_seq done held", 64'(done[1]), 64'd0);
        end
        req[1] = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, drd, derr, mrd, merr);
        check("rst_seq reload", 64'(drd), 64'h11111111);
        idle(1, 1);

        // Req dropped during WAIT: access abandoned, nothing stored
        req[2] = 1'b1; we[2] = 1'b1; sz[2] = 2'd2; adr[2] = 32'h30; wd[2] = 32'h55AA55AA;
        @(posedge clk); #1;
        idle(2, 4);
        txn(2, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, drd, derr, mrd, merr);
        check("abort reload", 64'(drd), 64'h0C0C0C0C);
        idle(2, 1);

        // Random traffic, back-to-back unless a gap is drawn
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 150; i++) begin
                w    = 1'($urandom_range(0, 1));
                s    = 2'($urandom_range(0, 3));
                u    = 1'($urandom_range(0, 1));
                a    = 32'($urandom_range(0, 1023));
                wdat = $urandom;
                txn(d, w, s, u, a, wdat, drd, derr, mrd, merr);
                check($sformatf("rand d%0d i%0d err", d, i), 64'(derr), 64'(merr));
                if (!w) check($sformatf("rand d%0d i%0d rdata a=%h", d, i, a), 64'(drd), 64'(mrd));
                if ($urandom_range(0, 3) == 0) idle(d, int'($urandom_range(1, 3)));
            end
            idle(d, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
